// File: rtl/mac_stats_pkg.sv
// Purpose: shared constants and types for the multi-port MAC management statistics block.
// Latency: n/a (definitions only).
// Backpressure: n/a. Holds the counter index map, mgnt word field positions and register address slices.
package mac_stats_pkg;

   localparam int NUM_CNT = 8;

   typedef enum logic [2:0] {
      CNT_RX_FRAMES  = 3'd0,
      CNT_RX_BYTES   = 3'd1,
      CNT_RX_CRC_ERR = 3'd2,
      CNT_RX_LEN_ERR = 3'd3,
      CNT_RX_TTE     = 3'd4,
      CNT_TX_FRAMES  = 3'd5,
      CNT_TX_BYTES   = 3'd6,
      CNT_TX_TTE     = 3'd7
   } cnt_idx_e;

   // Per-port mgnt word layout
   localparam int RX_W        = 20;
   localparam int TX_W        = 16;
   localparam int LEN_LSB     = 0;
   localparam int LEN_W       = 12;
   localparam int RX_CRC_BIT  = 12;
   localparam int RX_LEN_BIT  = 13;
   localparam int RX_TTE_BIT  = 14;
   localparam int RX_RSVD_LSB = 15;
   localparam int RX_RSVD_W   = 5;
   localparam int TX_TTE_BIT  = 12;
   localparam int TX_RSVD_LSB = 13;
   localparam int TX_RSVD_W   = 3;

   // Register address slices: [7:5] port, [4:2] counter index, [1:0] byte select
   localparam int ADDR_PORT_LSB = 5;
   localparam int ADDR_PORT_W   = 3;
   localparam int ADDR_IDX_LSB  = 2;
   localparam int ADDR_IDX_W    = 3;
   localparam int ADDR_BYTE_LSB = 0;
   localparam int ADDR_BYTE_W   = 2;

   // Identifies which counter the snapshot shadow currently holds
   typedef struct packed {
      logic [ADDR_PORT_W-1:0] port;
      logic [ADDR_IDX_W-1:0]  idx;
   } tag_t;

endpackage

// File: rtl/mac_mgnt_stats_mp_if.sv
// Purpose: byte-wide register request/response bus of the statistics block.
// Latency: response strobe follows request strobe by exactly 2 cycles.
// Backpressure: none; one request may be issued every cycle.
// Signals: sys_req_valid/wr/addr from requester, sys_resp_valid/data back to requester.
interface mac_mgnt_stats_mp_if;
   logic       sys_req_valid;
   logic       sys_req_wr;
   logic [7:0] sys_req_addr;
   logic       sys_resp_valid;
   logic [7:0] sys_resp_data;

   modport master (
      output sys_req_valid, sys_req_wr, sys_req_addr,
      input  sys_resp_valid, sys_resp_data
   );

   modport slave (
      input  sys_req_valid, sys_req_wr, sys_req_addr,
      output sys_resp_valid, sys_resp_data
   );
endinterface

// File: rtl/mac_stat_cnt.sv
// Purpose: one statistics counter cell; clear is applied before the add, then saturate or wrap.
// Latency: new value visible the cycle after inc_en/clr are presented.
// Backpressure: none; accepts an update every cycle.
// Ports: clk, rst, inc_en, inc_val, clr in; cnt out.
module mac_stat_cnt #(
   parameter int CNT_W    = 32,
   parameter int SATURATE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_en,
   input  logic [CNT_W-1:0] inc_val,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] base;
   logic [CNT_W:0]   sum;

   always_comb begin
      // A clear in the same cycle as an event zeroes first, so the event still counts
      base  = clr ? '0 : cnt_q;
      sum   = {1'b0, base} + {1'b0, inc_val};
      cnt_d = base;
      if (inc_en) begin
         if (sum[CNT_W] && (SATURATE != 0)) cnt_d = '1;
         else                               cnt_d = sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mac_mgnt_stats_mp.sv
// Purpose: per-port RX/TX management event counters (8 per port) read/cleared over a byte-wide register bus.
// Latency: events count and pulse resp 1 cycle after acceptance; register response 2 cycles after request.
// Backpressure: event accepted when valid=1 and resp=0 (held valid re-accepts every 2 cycles); register bus never stalls.
// Ports: clk, rst; rx/tx_mgnt_valid/data in, rx/tx_mgnt_resp out per port; sys (slave modport) register bus.
module mac_mgnt_stats_mp
   import mac_stats_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int CNT_W     = 32,
   parameter int SATURATE  = 1,
   parameter int CLR_ON_RD = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_PORTS-1:0]      rx_mgnt_valid,
   input  logic [RX_W*NUM_PORTS-1:0] rx_mgnt_data,
   output logic [NUM_PORTS-1:0]      rx_mgnt_resp,
   input  logic [NUM_PORTS-1:0]      tx_mgnt_valid,
   input  logic [TX_W*NUM_PORTS-1:0] tx_mgnt_data,
   output logic [NUM_PORTS-1:0]      tx_mgnt_resp,
   mac_mgnt_stats_mp_if.slave        sys
);

   localparam logic [CNT_W-1:0]       ONE = CNT_W'(1);
   localparam logic [ADDR_PORT_W:0]   NP  = (ADDR_PORT_W+1)'(NUM_PORTS);

   logic [NUM_PORTS-1:0] rx_acc, tx_acc;
   logic [NUM_PORTS-1:0] rx_resp_q, rx_resp_d, tx_resp_q, tx_resp_d;

   logic             inc_en  [NUM_PORTS][NUM_CNT];
   logic [CNT_W-1:0] inc_val [NUM_PORTS][NUM_CNT];
   logic             clr     [NUM_PORTS][NUM_CNT];
   logic [CNT_W-1:0] cnt     [NUM_PORTS][NUM_CNT];

   logic [ADDR_PORT_W-1:0] req_port;
   logic [ADDR_IDX_W-1:0]  req_idx;
   logic [ADDR_BYTE_W-1:0] req_byte;
   tag_t                   req_tag;
   logic                   port_ok, clr_hit;
   logic [CNT_W-1:0]       rx_len, tx_len, sel_cnt, rd_src;
   logic [7:0]             rd_dat;
   logic                   unused_rsvd;

   logic [CNT_W-1:0] shadow_q, shadow_d;
   tag_t             tag_q, tag_d;
   logic             s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
   logic [7:0]       s1_dat_q, s1_dat_d, out_dat_q, out_dat_d;

   always_comb begin
      rx_acc    = rx_mgnt_valid & ~rx_resp_q;
      tx_acc    = tx_mgnt_valid & ~tx_resp_q;
      rx_resp_d = rx_acc;
      tx_resp_d = tx_acc;

      req_port = sys.sys_req_addr[ADDR_PORT_LSB +: ADDR_PORT_W];
      req_idx  = sys.sys_req_addr[ADDR_IDX_LSB  +: ADDR_IDX_W];
      req_byte = sys.sys_req_addr[ADDR_BYTE_LSB +: ADDR_BYTE_W];
      req_tag  = '{port: req_port, idx: req_idx};
      port_ok  = {1'b0, req_port} < NP;
      // Write always clears; a byte-0 read also clears when clear-on-read is enabled
      clr_hit  = sys.sys_req_valid && port_ok &&
                 (sys.sys_req_wr || ((CLR_ON_RD != 0) && (req_byte == '0)));

      rx_len      = '0;
      tx_len      = '0;
      sel_cnt     = '0;
      unused_rsvd = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         rx_len = CNT_W'(rx_mgnt_data[p*RX_W + LEN_LSB +: LEN_W]);
         tx_len = CNT_W'(tx_mgnt_data[p*TX_W + LEN_LSB +: LEN_W]);
         unused_rsvd ^= ^rx_mgnt_data[p*RX_W + RX_RSVD_LSB +: RX_RSVD_W];
         unused_rsvd ^= ^tx_mgnt_data[p*TX_W + TX_RSVD_LSB +: TX_RSVD_W];
         for (int c = 0; c < NUM_CNT; c++) begin
            inc_val[p][c] = ONE;
            clr[p][c]     = clr_hit && (req_port == 3'(p)) && (req_idx == 3'(c));
            if ((req_port == 3'(p)) && (req_idx == 3'(c))) sel_cnt = cnt[p][c];
         end
         inc_en[p][CNT_RX_FRAMES]  = rx_acc[p];
         inc_en[p][CNT_RX_BYTES]   = rx_acc[p];
         inc_en[p][CNT_RX_CRC_ERR] = rx_acc[p] & rx_mgnt_data[p*RX_W + RX_CRC_BIT];
         inc_en[p][CNT_RX_LEN_ERR] = rx_acc[p] & rx_mgnt_data[p*RX_W + RX_LEN_BIT];
         inc_en[p][CNT_RX_TTE]     = rx_acc[p] & rx_mgnt_data[p*RX_W + RX_TTE_BIT];
         inc_en[p][CNT_TX_FRAMES]  = tx_acc[p];
         inc_en[p][CNT_TX_BYTES]   = tx_acc[p];
         inc_en[p][CNT_TX_TTE]     = tx_acc[p] & tx_mgnt_data[p*TX_W + TX_TTE_BIT];
         inc_val[p][CNT_RX_BYTES]  = rx_len;
         inc_val[p][CNT_TX_BYTES]  = tx_len;
      end

      // Upper bytes come from the snapshot only if it belongs to this counter
      rd_src = ((req_byte != '0) && (tag_q == req_tag)) ? shadow_q : sel_cnt;
      rd_dat = 8'h00;
      for (int b = 0; b < CNT_W/8; b++) begin
         if (req_byte == 2'(b)) rd_dat = rd_src[b*8 +: 8];
      end
      if (sys.sys_req_wr || !port_ok) rd_dat = 8'h00;

      shadow_d = shadow_q;
      tag_d    = tag_q;
      if (sys.sys_req_valid && !sys.sys_req_wr && port_ok && (req_byte == '0)) begin
         shadow_d = sel_cnt;
         tag_d    = req_tag;
      end

      s1_vld_d  = sys.sys_req_valid;
      s1_dat_d  = sys.sys_req_valid ? rd_dat : 8'h00;
      out_vld_d = s1_vld_q;
      out_dat_d = s1_dat_q;
   end

   for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
      for (genvar gc = 0; gc < NUM_CNT; gc++) begin : g_cnt
         mac_stat_cnt #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
         ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_en  (inc_en[gp][gc]),
            .inc_val (inc_val[gp][gc]),
            .clr     (clr[gp][gc]),
            .cnt     (cnt[gp][gc])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_resp_q <= '0;
         tx_resp_q <= '0;
         shadow_q  <= '0;
         tag_q     <= '0;
         s1_vld_q  <= 1'b0;
         s1_dat_q  <= 8'h00;
         out_vld_q <= 1'b0;
         out_dat_q <= 8'h00;
      end else begin
         rx_resp_q <= rx_resp_d;
         tx_resp_q <= tx_resp_d;
         shadow_q  <= shadow_d;
         tag_q     <= tag_d;
         s1_vld_q  <= s1_vld_d;
         s1_dat_q  <= s1_dat_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
      end
   end

   assign rx_mgnt_resp       = rx_resp_q;
   assign tx_mgnt_resp       = tx_resp_q;
   assign sys.sys_resp_valid = out_vld_q;
   assign sys.sys_resp_data  = out_dat_q;

endmodule

// File: tb/tb_mac_mgnt_stats_mp.sv
// Purpose: directed self-checking bench for mac_mgnt_stats_mp (32-bit saturating, 16-bit saturating, 16-bit wrap + clear-on-read).
// Latency: checks 2-cycle register response and 1-cycle event resp pulse.
// Backpressure: exercises held-valid re-accept and simultaneous all-port events.
module tb_mac_mgnt_stats_mp;

   localparam int NP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NP-1:0]    rx_vld = '0, tx_vld = '0;
   logic [20*NP-1:0] rx_dat = '0;
   logic [16*NP-1:0] tx_dat = '0;
   logic [NP-1:0]    rx_resp_a, tx_resp_a, rx_resp_b, tx_resp_b, rx_resp_c, tx_resp_c;
   logic             req_vld = 1'b0, req_wr = 1'b0;
   logic [7:0]       req_addr = 8'h00;

   int checks   = 0;
   int failures = 0;

   mac_mgnt_stats_mp_if bus_a ();
   mac_mgnt_stats_mp_if bus_b ();
   mac_mgnt_stats_mp_if bus_c ();

   assign bus_a.sys_req_valid = req_vld;
   assign bus_a.sys_req_wr    = req_wr;
   assign bus_a.sys_req_addr  = req_addr;
   assign bus_b.sys_req_valid = req_vld;
   assign bus_b.sys_req_wr    = req_wr;
   assign bus_b.sys_req_addr  = req_addr;
   assign bus_c.sys_req_valid = req_vld;
   assign bus_c.sys_req_wr    = req_wr;
   assign bus_c.sys_req_addr  = req_addr;

   mac_mgnt_stats_mp #(.NUM_PORTS(NP), .CNT_W(32), .SATURATE(1), .CLR_ON_RD(0)) u_dut (
      .clk(clk), .rst(rst),
      .rx_mgnt_valid(rx_vld), .rx_mgnt_data(rx_dat), .rx_mgnt_resp(rx_resp_a),
      .tx_mgnt_valid(tx_vld), .tx_mgnt_data(tx_dat), .tx_mgnt_resp(tx_resp_a),
      .sys(bus_a)
   );

   mac_mgnt_stats_mp #(.NUM_PORTS(NP), .CNT_W(16), .SATURATE(1), .CLR_ON_RD(0)) u_sat16 (
      .clk(clk), .rst(rst),
      .rx_mgnt_valid(rx_vld), .rx_mgnt_data(rx_dat), .rx_mgnt_resp(rx_resp_b),
      .tx_mgnt_valid(tx_vld), .tx_mgnt_data(tx_dat), .tx_mgnt_resp(tx_resp_b),
      .sys(bus_b)
   );

   mac_mgnt_stats_mp #(.NUM_PORTS(NP), .CNT_W(16), .SATURATE(0), .CLR_ON_RD(1)) u_wrap16 (
      .clk(clk), .rst(rst),
      .rx_mgnt_valid(rx_vld), .rx_mgnt_data(rx_dat), .rx_mgnt_resp(rx_resp_c),
      .tx_mgnt_valid(tx_vld), .tx_mgnt_data(tx_dat), .tx_mgnt_resp(tx_resp_c),
      .sys(bus_c)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      rst = 1'b1; rx_vld = '0; tx_vld = '0; rx_dat = '0; tx_dat = '0;
      req_vld = 1'b0; req_wr = 1'b0; req_addr = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_resp_valid", bus_a.sys_resp_valid, 0);
      chk("rst_resp_data", bus_a.sys_resp_data, 0);
      chk("rst_evt_resp", {rx_resp_a, tx_resp_a}, 0);
      rst = 1'b0;
   endtask

   // Issue one request; returns the response byte of each DUT
   task automatic req(input logic wr, input logic [7:0] addr,
                      output logic [7:0] da, output logic [7:0] db, output logic [7:0] dc);
      @(negedge clk);
      req_vld = 1'b1; req_wr = wr; req_addr = addr;
      @(negedge clk);
      req_vld = 1'b0; req_wr = 1'b0;
      chk("resp_early", bus_a.sys_resp_valid, 0);
      @(negedge clk);
      chk("resp_vld", bus_a.sys_resp_valid, 1);
      da = bus_a.sys_resp_data;
      db = bus_b.sys_resp_data;
      dc = bus_c.sys_resp_data;
   endtask

   task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      logic [7:0] a, b, c;
      req(1'b0, addr, a, b, c);
      chk(tag, a, exp);
   endtask

   task automatic rx_ev(input int p, input logic [11:0] len, input logic [2:0] flags);
      @(negedge clk);
      rx_vld[p] = 1'b1;
      rx_dat[p*20 +: 20] = {5'b0, flags, len};
      @(negedge clk);
      chk("rx_resp_pulse", rx_resp_a[p], 1);
      rx_vld[p] = 1'b0;
      @(negedge clk);
      chk("rx_resp_end", rx_resp_a[p], 0);
   endtask

   task automatic tx_ev(input int p, input logic [11:0] len, input logic tte);
      @(negedge clk);
      tx_vld[p] = 1'b1;
      tx_dat[p*16 +: 16] = {3'b0, tte, len};
      @(negedge clk);
      chk("tx_resp_pulse", tx_resp_a[p], 1);
      tx_vld[p] = 1'b0;
      @(negedge clk);
      chk("tx_resp_end", tx_resp_a[p], 0);
   endtask

   initial begin
      logic [1:0] vpipe;
      logic [7:0] a, b, c;
      logic [7:0] exp;

      // Reset, then back-to-back reads of every valid-port address
      rst_pulse();
      vpipe = 2'b00;
      for (int i = 0; i < 131; i++) begin
         @(negedge clk);
         chk("sweep_vld", bus_a.sys_resp_valid, vpipe[1]);
         if (vpipe[1]) chk("sweep_dat", bus_a.sys_resp_data, 0);
         vpipe    = {vpipe[0], (i < 128)};
         req_vld  = (i < 128);
         req_wr   = 1'b0;
         req_addr = 8'(i);
      end

      // Port 2 RX event with crc_err
      rx_ev(2, 12'h05E, 3'b001);
      rd("p2_rx_bytes", 8'h44, 8'h5E);
      rd("p2_rx_crc", 8'h48, 8'h01);
      rd("p2_rx_len_err", 8'h4C, 8'h00);
      rd("p2_rx_frames", 8'h40, 8'h01);
      rd("p2_tx_frames", 8'h54, 8'h00);

      // Snapshot consistency on port 0 tx_bytes
      rst_pulse();
      tx_ev(0, 12'h0FF, 1'b0);
      rd("snap_b0", 8'h18, 8'hFF);
      tx_ev(0, 12'h001, 1'b0);
      rd("snap_b1", 8'h19, 8'h00);
      rd("snap_b2", 8'h1A, 8'h00);
      rd("snap_b3", 8'h1B, 8'h00);
      rd("p0_tx_frames", 8'h14, 8'h02);
      rd("live_b1", 8'h19, 8'h01);
      rd("live_b0", 8'h18, 8'h00);

      // Saturate vs wrap: 16 x 0xFFF = 0xFFF0, then +0x20
      rst_pulse();
      for (int i = 0; i < 16; i++) tx_ev(0, 12'hFFF, 1'b0);
      tx_ev(0, 12'h020, 1'b0);
      req(1'b0, 8'h18, a, b, c);
      chk("ovf32_b0", a, 8'h10);
      chk("sat16_b0", b, 8'hFF);
      chk("wrap16_b0", c, 8'h10);
      req(1'b0, 8'h19, a, b, c);
      chk("ovf32_b1", a, 8'h00);
      chk("sat16_b1", b, 8'hFF);
      chk("wrap16_b1", c, 8'h00);
      req(1'b0, 8'h1A, a, b, c);
      chk("ovf32_b2", a, 8'h01);
      chk("sat16_b2_hi", b, 8'h00);
      chk("wrap16_b2_hi", c, 8'h00);
      req(1'b0, 8'h18, a, b, c);
      chk("ovf32_b0_again", a, 8'h10);
      chk("sat16_b0_again", b, 8'hFF);
      chk("wrap16_clr_on_rd", c, 8'h00);

      // Clear and event on the same counter in the same cycle
      rst_pulse();
      rx_ev(1, 12'h010, 3'b000);
      rx_ev(1, 12'h020, 3'b000);
      @(negedge clk);
      rx_vld[1] = 1'b1; rx_dat[1*20 +: 20] = {8'h00, 12'h005};
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 8'h20;
      @(negedge clk);
      chk("clr_evt_resp", rx_resp_a[1], 1);
      rx_vld[1] = 1'b0; req_vld = 1'b0; req_wr = 1'b0;
      @(negedge clk);
      chk("wr_resp_vld", bus_a.sys_resp_valid, 1);
      chk("wr_resp_dat", bus_a.sys_resp_data, 0);
      rd("clr_evt_frames", 8'h20, 8'h01);
      rd("clr_evt_bytes", 8'h24, 8'h35);

      // All ports, both directions, same cycle
      rst_pulse();
      @(negedge clk);
      rx_vld = '1; tx_vld = '1;
      for (int p = 0; p < NP; p++) begin
         rx_dat[p*20 +: 20] = {8'h00, 12'h040};
         tx_dat[p*16 +: 16] = {4'h0, 12'h040};
      end
      @(negedge clk);
      chk("all_rx_resp", rx_resp_a, 4'hF);
      chk("all_tx_resp", tx_resp_a, 4'hF);
      rx_vld = '0; tx_vld = '0;
      @(negedge clk);
      chk("all_resp_end", {rx_resp_a, tx_resp_a}, 0);
      for (int p = 0; p < NP; p++) begin
         for (int cc = 0; cc < 8; cc++) begin
            if (cc == 0 || cc == 5)      exp = 8'h01;
            else if (cc == 1 || cc == 6) exp = 8'h40;
            else                         exp = 8'h00;
            rd($sformatf("all_p%0d_c%0d", p, cc), {3'(p), 3'(cc), 2'b00}, exp);
         end
      end

      // Out-of-range port: write is harmless, reads give zero
      req(1'b1, 8'h84, a, b, c);
      chk("badport_wr_dat", a, 8'h00);
      rd("badport_no_alias", 8'h04, 8'h40);
      rd("badport_rd4", 8'h84, 8'h00);
      rd("badport_rd7", 8'hE0, 8'h00);

      // Valid held for 4 cycles on port 3 re-accepts every 2 cycles
      @(negedge clk);
      rx_vld[3] = 1'b1; rx_dat[3*20 +: 20] = {8'h00, 12'h010};
      repeat (4) @(negedge clk);
      rx_vld[3] = 1'b0;
      @(negedge clk);
      rd("held_frames", 8'h60, 8'h03);
      rd("held_bytes", 8'h64, 8'h60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
